// File: rtl/mux16_scan_ctrl_if.sv
// Host and mux-side signal bundle for mux16_scan_ctrl.
// master = host/mux model driving requests and mux_out; slave = the controller.
interface mux16_scan_ctrl_if;
  logic        start;
  logic [15:0] mask;
  logic        abort;
  logic        mux_out;
  logic [3:0]  mux_sel;
  logic        mux_en_n;
  logic        busy;
  logic        done;
  logic [15:0] result;

  modport master (
    output start, mask, abort, mux_out,
    input  mux_sel, mux_en_n, busy, done, result
  );

  modport slave (
    input  start, mask, abort, mux_out,
    output mux_sel, mux_en_n, busy, done, result
  );
endinterface

// File: rtl/mux16_scan_ctrl.sv
// Round-robin scan of a channel mask over a 16:1 inverting mux; one SEEK plus SETTLE enable cycles per channel.
// No backpressure: start is accepted only in IDLE, abort cancels a running scan on the next edge.
module mux16_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input logic              clk,
  input logic              rst_n,
  mux16_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEK   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(SETTLE - 1);

  state_t      r_state;
  logic [3:0]  r_sel;
  logic [3:0]  r_ptr;
  logic [3:0]  r_cnt;
  logic [15:0] r_pend;
  logic [15:0] r_result;

  state_t      w_state_nxt;
  logic [3:0]  w_sel_nxt;
  logic [3:0]  w_ptr_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [15:0] w_pend_nxt;
  logic [15:0] w_result_nxt;

  logic        w_found;
  logic [3:0]  w_seek_idx;

  // First pending channel at or after the pointer, wrapping 15 -> 0.
  always_comb begin
    logic [3:0] w_idx;
    w_found    = 1'b0;
    w_seek_idx = r_ptr;
    w_idx      = r_ptr;
    for (int i = 0; i < 16; i++) begin
      w_idx = r_ptr + 4'(i);
      if (!w_found && r_pend[w_idx]) begin
        w_found    = 1'b1;
        w_seek_idx = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= 4'd0;
      r_ptr    <= 4'd0;
      r_cnt    <= 4'd0;
      r_pend   <= 16'd0;
      r_result <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pend   <= w_pend_nxt;
      r_result <= w_result_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    w_pend_nxt   = r_pend;
    w_result_nxt = r_result;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_result_nxt = 16'd0;
          if (bus.mask != 16'd0) begin
            w_pend_nxt  = bus.mask;
            w_state_nxt = ST_SEEK;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end

      ST_SEEK: begin
        if (bus.abort) begin
          w_pend_nxt  = 16'd0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_sel_nxt   = w_seek_idx;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_SETTLE;
          if (w_found) begin
            w_pend_nxt[w_seek_idx] = 1'b0;
          end
        end
      end

      ST_SETTLE: begin
        // Abort beats a coincident capture: nothing is written on that edge.
        if (bus.abort) begin
          w_pend_nxt  = 16'd0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == LP_LAST) begin
          w_result_nxt[r_sel] = ~bus.mux_out;
          w_ptr_nxt           = r_sel + 4'd1;
          w_state_nxt         = (r_pend != 16'd0) ? ST_SEEK : ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.mux_sel  = r_sel;
  assign bus.mux_en_n = (r_state != ST_SETTLE);
  assign bus.busy     = (r_state == ST_SEEK) || (r_state == ST_SETTLE);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.result   = r_result;

endmodule
